cmos_cfg_sequencer: RTL and testbench

Sequences the CMOS sensor register-programming pass. On a start pulse it walks a configuration table of (10-bit command address, 16-bit data) entries and hands each entry to the downstream serial register writer over a valid/ready handshake. It honours embedded delay entries and enforces a minimum gap between writes. It sits between the power-up/reset control logic and the sensor SPI write engine, and replaces free-running address/data generation with an ordered, handshaked, completion-reporting sequence.

---
 rtl/cmos_cfg_sequencer_pkg.sv | 32 +++
 rtl/cmos_cfg_sequencer_table.sv | 42 ++++
 rtl/cmos_cfg_sequencer.sv | 127 ++++++++++++
 tb/tb_cmos_cfg_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_cfg_sequencer_pkg.sv
// cmos_cfg_defs
//   Shared definitions for the CMOS sensor configuration path: sequencer
//   FSM state encodings, the delay-entry marker address, the command-address
//   and write-data widths used by the sequencer, the table ROM and the
//   serial writer, and a helper that sizes the sequencer's cycle counter.
package cmos_cfg_defs;

  localparam int CMD_ADDR_W = 10;
  localparam int WR_DATA_W  = 16;

  // Table entries carrying this command address are waits, not writes.
  localparam logic [CMD_ADDR_W-1:0] DELAY_ADDR_DEFAULT = 10'h3FF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DELAY = 3'd5;
  localparam logic [2:0] ST_NEXT  = 3'd6;

  // One counter serves gap, delay and timeout, so it must hold the largest
  // of the gap length, the timeout length and a full 16-bit delay value.
  function automatic int cnt_width(input int gap_cycles, input int timeout_cycles);
    int m;
    m = 65535;
    if (gap_cycles > m)     m = gap_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cmos_cfg_sequencer_table.sv
// cmos_cfg_table
//   Synchronous configuration ROM with one cycle of read latency. Sits
//   beside the sequencer so a different table can be dropped in per sensor
//   mode. Rows past the populated ones, and any index at or beyond
//   NUM_ENTRIES, read back as zero-length delay entries so they never
//   produce a write.
// Ports:
//   clk_in   - clock, rising edge
//   index    - read index (from the sequencer's tbl_index)
//   cmd_addr - command address of the selected row, valid one cycle later
//   data     - data of the selected row, same latency
module cmos_cfg_table
  import cmos_cfg_defs::*;
#(
  parameter int NUM_ENTRIES = 32,
  parameter int IDX_W       = 10
) (
  input  logic                  clk_in,
  input  logic [IDX_W-1:0]      index,
  output logic [CMD_ADDR_W-1:0] cmd_addr,
  output logic [WR_DATA_W-1:0]  data
);

  function automatic logic [CMD_ADDR_W+WR_DATA_W-1:0] rom_word(input logic [IDX_W-1:0] i);
    logic [CMD_ADDR_W+WR_DATA_W-1:0] w;
    w = {DELAY_ADDR_DEFAULT, 16'h0000};
    if (int'(i) < NUM_ENTRIES) begin
      case (i)
        IDX_W'(0): w = {10'h005, 16'h0001};
        IDX_W'(1): w = {10'h022, 16'h0000};
        IDX_W'(2): w = {10'h0A0, 16'h1234};
        default:   w = {DELAY_ADDR_DEFAULT, 16'h0000};
      endcase
    end
    return w;
  endfunction

  always_ff @(posedge clk_in) begin
    {cmd_addr, data} <= rom_word(index);
  end

endmodule

// File: rtl/cmos_cfg_sequencer.sv
// cmos_cfg_sequencer
//   Walks the configuration table once per start pulse and hands each
//   (command address, data) entry to the serial register writer over a
//   valid/ready handshake. Delay entries stall the walk without writing,
//   a fixed idle gap follows every accepted write, and a write that is not
//   accepted within TIMEOUT_CYCLES aborts the pass with a sticky error.
// Ports:
//   clk_in, reset             - clock and synchronous active-high reset
//   start                     - one-cycle pulse, honoured only when idle
//   tbl_index                 - table read index
//   tbl_cmd_addr, tbl_data    - table row, one cycle after tbl_index
//   command_address, data     - write payload to the serial writer
//   wr_valid, wr_ready        - write handshake
//   busy, done, err           - pass in progress / pass complete / timeout
module cmos_cfg_sequencer
  import cmos_cfg_defs::*;
#(
  parameter int NUM_ENTRIES    = 32,
  parameter int IDX_W          = 10,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter logic [CMD_ADDR_W-1:0] DELAY_ADDR = DELAY_ADDR_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  start,
  output logic [IDX_W-1:0]      tbl_index,
  input  logic [CMD_ADDR_W-1:0] tbl_cmd_addr,
  input  logic [WR_DATA_W-1:0]  tbl_data,
  output logic [CMD_ADDR_W-1:0] command_address,
  output logic [WR_DATA_W-1:0]  data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  // Gap/delay down-counter, reused as the timeout up-counter in ISSUE.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      tbl_index       <= '0;
      command_address <= '0;
      data            <= '0;
      wr_valid        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            tbl_index <= '0;
            busy      <= 1'b1;
            err       <= 1'b0;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          if (tbl_cmd_addr == DELAY_ADDR) begin
            // Counter is preloaded with N-1 so DELAY lasts exactly N cycles;
            // a zero-length delay skips the DELAY state entirely.
            if (tbl_data == '0) begin
              state <= ST_NEXT;
            end else begin
              cnt   <= CNT_W'(tbl_data) - CNT_W'(1);
              state <= ST_DELAY;
            end
          end else begin
            command_address <= tbl_cmd_addr;
            data            <= tbl_data;
            wr_valid        <= 1'b1;
            cnt             <= '0;
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A handshake in the final allowed cycle still counts as success.
          if (wr_valid && wr_ready) begin
            wr_valid <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state <= ST_NEXT;
            end else begin
              cnt   <= GAP_LOAD;
              state <= ST_GAP;
            end
          end else if (cnt == TMO_LAST) begin
            wr_valid <= 1'b0;
            err      <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP, ST_DELAY: begin
          if (cnt == '0) state <= ST_NEXT;
          else           cnt   <= cnt - 1'b1;
        end
        ST_NEXT: begin
          if (tbl_index == LAST_IDX) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tbl_index <= tbl_index + 1'b1;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_cfg_sequencer.sv
// tb_cmos_cfg_sequencer
//   Scoreboard bench for cmos_cfg_sequencer with a 3-entry table, a 2-cycle
//   write gap and an 8-cycle handshake timeout. The table is served either
//   by cmos_cfg_table or by a bench-side registered model whose rows can be
//   edited between passes.
module tb_cmos_cfg_sequencer;
  import cmos_cfg_defs::*;

  localparam int N   = 3;
  localparam int GAP = 2;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset, start, wr_ready, use_rom;
  logic [9:0]  tbl_index, tbl_cmd_addr, command_address;
  logic [15:0] tbl_data, data;
  logic        wr_valid, busy, done, err;

  logic [9:0]  tb_a [N];
  logic [15:0] tb_d [N];
  logic [9:0]  mdl_a, rom_a;
  logic [15:0] mdl_d, rom_d;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tbl_index < 10'(N)) begin
      mdl_a <= tb_a[tbl_index[1:0]];
      mdl_d <= tb_d[tbl_index[1:0]];
    end
  end

  assign tbl_cmd_addr = use_rom ? rom_a : mdl_a;
  assign tbl_data     = use_rom ? rom_d : mdl_d;

  cmos_cfg_table #(.NUM_ENTRIES(N), .IDX_W(10)) u_tbl (
    .clk_in(clk), .index(tbl_index), .cmd_addr(rom_a), .data(rom_d)
  );

  cmos_cfg_sequencer #(
    .NUM_ENTRIES(N), .IDX_W(10), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk), .reset(reset), .start(start),
    .tbl_index(tbl_index), .tbl_cmd_addr(tbl_cmd_addr), .tbl_data(tbl_data),
    .command_address(command_address), .data(data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0, done_cnt = 0, vld_cyc = 0, bad_delay = 0;
  int hs_cyc[$];
  logic [25:0] exp_q[$];
  logic [25:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_valid) vld_cyc++;
    if (wr_valid && command_address == DELAY_ADDR_DEFAULT) bad_delay++;
    if (done) done_cnt++;
    if (wr_valid && wr_ready) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", {22'd0, command_address}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_addr", {22'd0, command_address}, {22'd0, mon_e[25:16]});
        chk("sb_data", {16'd0, data}, {16'd0, mon_e[15:0]});
      end
    end
  end

  task automatic set_plan_table();
    tb_a[0] = 10'h005; tb_d[0] = 16'h0001;
    tb_a[1] = 10'h022; tb_d[1] = 16'h0000;
    tb_a[2] = 10'h0A0; tb_d[2] = 16'h1234;
  endtask

  task automatic push_expected();
    for (int i = 0; i < N; i++)
      if (tb_a[i] != DELAY_ADDR_DEFAULT) exp_q.push_back({tb_a[i], tb_d[i]});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Waits for done or err; optionally re-pulses start mid-pass.
  task automatic wait_end(input string tag, input int extra);
    bit fin;
    fin = 1'b0;
    for (int n = 0; n < 300 && !fin; n++) begin
      @(negedge clk);
      if (n == extra) start = 1'b1;
      else            start = 1'b0;
      if (done || err) fin = 1'b1;
    end
    start = 1'b0;
    if (!fin) chk({tag, "_pass_end"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_pass(input string tag, input int extra);
    pulse_start();
    @(negedge clk);
    chk({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
    chk({tag, "_err_clr"}, {31'd0, err}, 32'd0);
    chk({tag, "_idx0"}, {22'd0, tbl_index}, 32'd0);
    wait_end(tag, extra);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_idx"},  {22'd0, tbl_index}, 32'd0);
    chk({tag, "_addr"}, {22'd0, command_address}, 32'd0);
    chk({tag, "_data"}, {16'd0, data}, 32'd0);
    chk({tag, "_vld"},  {31'd0, wr_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"},  {31'd0, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, h0, d0, v0, dz;
    bit seen;
    reset = 1'b1; start = 1'b0; wr_ready = 1'b0; use_rom = 1'b1;
    set_plan_table();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst");

    // Plain three-write pass from the ROM.
    wr_ready = 1'b1;
    base = hs_cyc.size(); h0 = hs_cnt; d0 = done_cnt;
    push_expected();
    run_pass("t1", -1);
    chk("t1_hs", hs_cnt - h0, 3);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_busy", {31'd0, busy}, 0);
    chk("t1_err", {31'd0, err}, 0);
    chk("t1_sb_empty", exp_q.size(), 0);
    chk("t1_spacing", hs_cyc[base+1] - hs_cyc[base], 6);

    // Delay entry in the middle: zero-length, then 10 cycles.
    use_rom = 1'b0;
    tb_a[1] = DELAY_ADDR_DEFAULT; tb_d[1] = 16'd0;
    base = hs_cyc.size();
    push_expected();
    run_pass("t2a", -1);
    dz = hs_cyc[base+1] - hs_cyc[base];
    chk("t2_zero_delay_span", dz, 9);
    tb_d[1] = 16'd10;
    base = hs_cyc.size();
    push_expected();
    run_pass("t2b", -1);
    chk("t2_delay_extra", hs_cyc[base+1] - hs_cyc[base] - dz, 10);
    chk("t2_no_delay_write", bad_delay, 0);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Back-pressure for 5 cycles on the first write.
    use_rom = 1'b1; set_plan_table();
    wr_ready = 1'b0;
    h0 = hs_cnt; d0 = done_cnt;
    push_expected();
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (wr_valid) seen = 1'b1;
    end
    chk("t3_vld_seen", {31'd0, seen}, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_vld", {31'd0, wr_valid}, 1);
      chk("t3_hold_addr", {22'd0, command_address}, 32'h005);
      chk("t3_hold_data", {16'd0, data}, 32'h0001);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 wr_ready = 1'b1;
    wait_end("t3", -1);
    chk("t3_hs", hs_cnt - h0, 3);
    chk("t3_done", done_cnt - d0, 1);
    chk("t3_sb_empty", exp_q.size(), 0);

    // Stuck ready: timeout, then a clean recovery pass.
    wr_ready = 1'b0;
    h0 = hs_cnt; d0 = done_cnt; v0 = vld_cyc;
    run_pass("t4", -1);
    chk("t4_err", {31'd0, err}, 1);
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_vld_cycles", vld_cyc - v0, TMO);
    chk("t4_no_hs", hs_cnt - h0, 0);
    wr_ready = 1'b1;
    h0 = hs_cnt; d0 = done_cnt;
    push_expected();
    run_pass("t4r", -1);
    chk("t4r_hs", hs_cnt - h0, 3);
    chk("t4r_done", done_cnt - d0, 1);
    chk("t4r_err", {31'd0, err}, 0);

    // Reset during the gap after entry 1, with start held during reset.
    h0 = hs_cnt; d0 = done_cnt;
    exp_q.push_back({tb_a[0], tb_d[0]});
    exp_q.push_back({tb_a[1], tb_d[1]});
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (wr_valid && wr_ready && command_address == 10'h022) seen = 1'b1;
    end
    chk("t5_entry1_hs", {31'd0, seen}, 1);
    @(posedge clk); #1 reset = 1'b1; start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_reset_vals("t5");
    repeat (3) @(negedge clk);
    chk("t5_idle_busy", {31'd0, busy}, 0);
    chk("t5_hs", hs_cnt - h0, 2);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_sb_empty", exp_q.size(), 0);
    h0 = hs_cnt; d0 = done_cnt;
    push_expected();
    run_pass("t5r", -1);
    chk("t5r_hs", hs_cnt - h0, 3);
    chk("t5r_done", done_cnt - d0, 1);

    // Second start pulse while busy is ignored.
    h0 = hs_cnt; d0 = done_cnt;
    push_expected();
    run_pass("t6", 5);
    repeat (20) @(negedge clk);
    chk("t6_done", done_cnt - d0, 1);
    chk("t6_hs", hs_cnt - h0, 3);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
